// File: rtl/mem_stage_sram_if.sv
// External 16-bit SRAM bus used by the memory stage.
// master : the memory stage (drives address, write data, output enable, write enable)
// slave  : the SRAM side / tristate wrapper (returns read data)
//   sramAddr  [17:0] half-word address
//   sramDqOut [15:0] write data
//   sramDqOe         drive sramDqOut onto the shared data bus
//   sramDqIn  [15:0] read data sampled from the bus
//   sramWeN          active-low write enable
interface mem_stage_sram_if;
  logic [17:0] sramAddr;
  logic [15:0] sramDqOut;
  logic        sramDqOe;
  logic [15:0] sramDqIn;
  logic        sramWeN;

  modport master (
    output sramAddr, sramDqOut, sramDqOe, sramWeN,
    input  sramDqIn
  );

  modport slave (
    input  sramAddr, sramDqOut, sramDqOe, sramWeN,
    output sramDqIn
  );
endinterface

// File: rtl/mem_stage_sram.sv
// Memory stage of the five-stage pipeline. Splits each 32-bit load/store into
// two 16-bit SRAM phases (low half, then high half), stalls the pipeline via
// `ready` while the access runs, and drives the MEM/WB pipeline register.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ALUResult, storeValue    address/result and store data from EXE/MEM
//   MEM_R_EN, MEM_W_EN,
//   WB_EN, destIn            enables and destination from EXE/MEM
//   ready                    0 = freeze upstream stages (combinational)
//   sram                     SRAM bus (master side)
//   wbWbEn, wbMemREn,
//   wbAluResult, wbMemData,
//   wbDest                   MEM/WB register outputs
//
// state | meaning
// IDLE  | waiting for a request; MEM/WB loads when no request is present
// LO    | low half-word phase, PHASE_CYCLES cycles
// HI    | high half-word phase, PHASE_CYCLES cycles
// DONE  | access complete for one cycle; ready high, MEM/WB loads
module mem_stage_sram #(
  parameter int          PHASE_CYCLES = 2,
  parameter logic [31:0] DATA_BASE    = 32'd1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            ALUResult,
  input  logic [31:0]            storeValue,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic                   WB_EN,
  input  logic [3:0]             destIn,
  output logic                   ready,
  mem_stage_sram_if.master       sram,
  output logic                   wbWbEn,
  output logic                   wbMemREn,
  output logic [31:0]            wbAluResult,
  output logic [31:0]            wbMemData,
  output logic [3:0]             wbDest
);

  localparam int CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] phaseCnt;
  logic [15:0]      loBuf;
  logic [15:0]      hiBuf;
  logic             req;
  logic             isStore;
  logic             phaseEnd;
  logic [16:0]      word;

  assign req      = MEM_R_EN | MEM_W_EN;
  // Both enables together is treated as a store.
  assign isStore  = MEM_W_EN;
  assign phaseEnd = (phaseCnt == LAST_PHASE);
  // Byte offset from the data base wraps modulo 2^32; only bits [18:2] address SRAM.
  assign word     = 17'((ALUResult - DATA_BASE) >> 2);
  assign ready    = ((state == IDLE) && !req) || (state == DONE);

  // Upstream stages are frozen while ready is low, so the EXE/MEM inputs
  // stay stable for the whole access and can be read in every phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      phaseCnt       <= '0;
      sram.sramAddr  <= '0;
      sram.sramDqOut <= '0;
      sram.sramDqOe  <= 1'b0;
      sram.sramWeN   <= 1'b1;
      loBuf          <= '0;
      hiBuf          <= '0;
      wbWbEn         <= 1'b0;
      wbMemREn       <= 1'b0;
      wbAluResult    <= '0;
      wbMemData      <= '0;
      wbDest         <= '0;
    end else begin
      if (ready) begin
        wbWbEn      <= WB_EN;
        wbMemREn    <= MEM_R_EN;
        wbAluResult <= ALUResult;
        wbMemData   <= {hiBuf, loBuf};
        wbDest      <= destIn;
      end

      unique case (state)
        IDLE: begin
          if (req) begin
            state         <= LO;
            phaseCnt      <= '0;
            sram.sramAddr <= {word, 1'b0};
            sram.sramDqOe <= isStore;
            sram.sramWeN  <= ~isStore;
            if (isStore) sram.sramDqOut <= storeValue[15:0];
          end
        end
        LO: begin
          if (phaseEnd) begin
            if (!isStore) loBuf <= sram.sramDqIn;
            state         <= HI;
            phaseCnt      <= '0;
            sram.sramAddr <= {word, 1'b1};
            if (isStore) sram.sramDqOut <= storeValue[31:16];
          end else begin
            phaseCnt <= phaseCnt + 1'b1;
          end
        end
        HI: begin
          if (phaseEnd) begin
            if (!isStore) hiBuf <= sram.sramDqIn;
            state         <= DONE;
            sram.sramDqOe <= 1'b0;
            sram.sramWeN  <= 1'b1;
          end else begin
            phaseCnt <= phaseCnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage_sram.md
# mem_stage_sram

Memory stage of the five-stage ARM pipeline. It consumes the EXE/MEM register outputs (ALU result, store value, memory and write-back enables, destination), performs 32-bit loads and stores against a 16-bit external SRAM, and drives the MEM/WB pipeline register. While an access is in progress it deasserts `ready`, and the hazard/freeze logic stalls every upstream stage.

## Interface
Parameters:
- `PHASE_CYCLES`, default 2: cycles the SRAM address/data are held per 16-bit half-word phase (≥1).
- `DATA_BASE`, default 1024: byte address mapped to SRAM word 0.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `ALUResult`  in  32  byte address for loads/stores; result value for ALU instructions.
- `storeValue`  in  32  data to store (Rm value).
- `MEM_R_EN`, `MEM_W_EN`, `WB_EN`  in  1 each  enables from the EXE/MEM register.
- `destIn`  in  4  write-back register index.
- `ready`  out  1  0 = freeze pipeline; combinational.
- `sramAddr`  out  18  half-word address.
- `sramDqOut`  out  16  write data.
- `sramDqOe`  out  1  drive `sramDqOut` onto the bus (the top level builds the tristate).
- `sramDqIn`  in  16  read data from the bus.
- `sramWeN`  out  1  active-low write enable.
- `wbWbEn`, `wbMemREn`  out  1 each  MEM/WB register copies of `WB_EN` and `MEM_R_EN`.
- `wbAluResult`, `wbMemData`  out  32 each  registered ALU result and loaded word.
- `wbDest`  out  4  registered destination.

## Operation
- Request: `req = MEM_R_EN | MEM_W_EN`. Both enables high together is illegal; the block treats that case as a store.
- Address mapping: `off = ALUResult - DATA_BASE` (32-bit wrap).
  - `word = off[18:2]`; `off[1:0]` is ignored.
  - Low half is at `sramAddr = {word,1'b0}`; high half is at `{word,1'b1}`.
- FSM states:
  - IDLE:
    - With `req`, go to LO and clear the phase counter.
    - Without `req`, stay in IDLE.
  - LO: stay for `PHASE_CYCLES` cycles, then go to HI and clear the counter.
  - HI: stay for `PHASE_CYCLES` cycles, then go to DONE.
  - DONE: one cycle, then unconditionally go to IDLE. The new instruction is sampled in IDLE, so the same access is never re-issued.
- `ready` = (IDLE & !req) | DONE.
- Store:
  - In LO: `sramDqOut = storeValue[15:0]`, `sramDqOe = 1`, `sramWeN = 0`.
  - In HI: the same, with `storeValue[31:16]`.
- Load:
  - `sramDqOe = 0` and `sramWeN = 1` throughout.
  - `sramDqIn` is captured into an internal low/high buffer on the last cycle of LO and of HI respectively.
- Outside LO/HI: `sramWeN = 1`, `sramDqOe = 0`, and `sramAddr` holds its last value.
- MEM/WB register:
  - Loads on every edge where `ready = 1`, i.e. IDLE without request, or DONE.
  - Captures `WB_EN`, `MEM_R_EN`, `ALUResult`, `destIn`, and `wbMemData` = {high buffer, low buffer}.
  - Holds its value while `ready = 0`.
  - A non-memory instruction passes through with one cycle of latency.

## Timing
- Reset values: state IDLE, counter 0, `sramWeN = 1`, `sramDqOe = 0`, `sramAddr = 0`, `sramDqOut = 0`, buffers 0, all `wb*` outputs 0.
- `rst` has priority over every transition.
- Reset during LO/HI aborts the access. `sramWeN` is high from the cycle after the reset edge, and the MEM/WB register stays 0.
- Memory access:
  - `ready` is low for 1 + 2·`PHASE_CYCLES` cycles (5 with the default), starting in the cycle the request is first presented.
  - `ready` is high in DONE.
  - MEM/WB holds the result from the edge that ends DONE.
- Back-to-back memory instructions: the IDLE cycle after DONE sees the next request and stalls again. There is no overlap of accesses.
- The phase counter is wide enough for `PHASE_CYCLES`. The `off` subtraction wraps modulo 2^32, and only bits [18:2] are used.

## Test plan
- ALU pass-through: `WB_EN = 1`, `ALUResult = 0x00000025`, `destIn = 3`, no `req` -> `ready` stays 1; one cycle later `wbWbEn = 1`, `wbAluResult = 0x25`, `wbDest = 3`; `sramWeN` stays 1.
- Store 0xDEADBEEF to 1024 -> `ready` low for 5 cycles.
  - LO: `sramAddr = 0`, `sramDqOut = 0xBEEF`, `sramWeN = 0` for 2 cycles.
  - HI: `sramAddr = 1`, `sramDqOut = 0xDEAD`, `sramWeN = 0` for 2 cycles.
  - DONE: `ready = 1`.
- Load from 1028 with the SRAM model holding 0x1234 at address 2 and 0xABCD at address 3 -> `sramAddr` 2 then 3, `sramWeN = 1`; after DONE, `wbMemData = 0xABCD1234` and `wbMemREn = 1`.
- Store to 1024 immediately followed by a load from 1024 -> two separate 5-cycle stalls with no `ready`-high gap other than DONE; the load returns 0xDEADBEEF.
- `rst` asserted in the 3rd cycle of a store -> from the next cycle `sramWeN = 1`, state IDLE, all `wb*` outputs 0; SRAM address 1 is unwritten.
- `PHASE_CYCLES = 1` build: load -> `ready` low for exactly 3 cycles, and data is captured in single-cycle phases.
